knap_subset_search: RTL

- Sequential brute-force knapsack search engine. It is the initiator that generates the candidate selections which the combinational knapsack validity oracle only judges.
- Enumerates every item subset, one per cycle. Evaluates total value and total weight against min_value/max_weight.
- Streams each feasible subset out on a valid/ready channel and reports the best feasible subset.
- Serves as the classical reference and solution generator beside the oracle.

---
 rtl/knap_subset_search.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/knap_subset_search.sv
// Brute-force knapsack search: one candidate subset per cycle, each feasible subset is streamed out in ascending order, and the best one is tracked.
// done follows start by 2^N_ITEMS+1 edges when never stalled; a held sol_valid stalls the search. Define KNAP_COUNT_EN to add the num_valid count.
module knap_subset_search #(
  parameter int N_ITEMS = 5,
  parameter int VAL_W   = 32,
  parameter int WT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_ITEMS*VAL_W-1:0] item_values,
  input  logic [N_ITEMS*WT_W-1:0]  item_weights,
  input  logic [VAL_W-1:0]         min_value,
  input  logic [WT_W-1:0]          max_weight,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [N_ITEMS-1:0]       best_sel,
  output logic [VAL_W+4:0]         best_value,
  output logic [WT_W+4:0]          best_weight,
`ifdef KNAP_COUNT_EN
  output logic [N_ITEMS:0]         num_valid,
`endif
  output logic                     sol_valid,
  input  logic                     sol_ready,
  output logic [N_ITEMS-1:0]       sol_sel
);

  localparam int TV_W = VAL_W + 5;
  localparam int TW_W = WT_W + 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [N_ITEMS-1:0]       cnt;
  logic [N_ITEMS*VAL_W-1:0] vals_q;
  logic [N_ITEMS*WT_W-1:0]  wts_q;
  logic [VAL_W-1:0]         min_q;
  logic [WT_W-1:0]          max_q;

  logic [TV_W-1:0] tot_v;
  logic [TW_W-1:0] tot_w;
  logic            feasible;
  logic            better;
  logic            slot_free;
  logic            last_cand;
  logic            advance;

  // Five guard bits hold the sum of up to 16 items without overflow.
  always_comb begin
    tot_v = '0;
    tot_w = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (cnt[i]) begin
        tot_v = tot_v + TV_W'(vals_q[i*VAL_W +: VAL_W]);
        tot_w = tot_w + TW_W'(wts_q[i*WT_W +: WT_W]);
      end
    end
    feasible  = (tot_v >= TV_W'(min_q)) && (tot_w <= TW_W'(max_q));
    better    = !found || (tot_v > best_value) ||
                ((tot_v == best_value) && (tot_w < best_weight));
    slot_free = !sol_valid || sol_ready;
    last_cand = (cnt == {N_ITEMS{1'b1}});
    advance   = (state == S_RUN) && (!feasible || slot_free);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      vals_q      <= '0;
      wts_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      best_sel    <= '0;
      best_value  <= '0;
      best_weight <= '0;
      sol_valid   <= 1'b0;
      sol_sel     <= '0;
`ifdef KNAP_COUNT_EN
      num_valid   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vals_q      <= item_values;
            wts_q       <= item_weights;
            min_q       <= min_value;
            max_q       <= max_weight;
            found       <= 1'b0;
            best_sel    <= '0;
            best_value  <= '0;
            best_weight <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= S_RUN;
`ifdef KNAP_COUNT_EN
            num_valid   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (feasible) begin
            if (slot_free) begin
              sol_sel   <= cnt;
              sol_valid <= 1'b1;
              found     <= 1'b1;
`ifdef KNAP_COUNT_EN
              num_valid <= num_valid + 1'b1;
`endif
              // Strict comparisons keep the earlier (lower index) subset on a full tie.
              if (better) begin
                best_sel    <= cnt;
                best_value  <= tot_v;
                best_weight <= tot_w;
              end
            end
          end else if (sol_ready) begin
            sol_valid <= 1'b0;
          end
          if (advance) begin
            cnt <= cnt + 1'b1;
            if (last_cand) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (slot_free) begin
            sol_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
